// File: rtl/spectrum_pkg.sv
// Shared constants for the spectrum bar display: bin geometry, scaling and frame timing.
// The colour stage imports HSTART/BIN_W from here so both sides agree on column spans.
package spectrum_pkg;

  localparam int NBINS  = 10;
  localparam int HSTART = 143;
  localparam int BIN_W  = 40;
  localparam int MAG_W  = 16;
  localparam int SHIFT  = 7;
  localparam int MAX_H  = 480;
  localparam int DECAY  = 4;
  localparam int VSWAP  = 512;
  localparam int H_W    = 9;

  typedef logic [H_W-1:0] height_t;

  // Column bounds: bin k covers BIN_BOUND[k] .. BIN_BOUND[k+1]-1.
  // Bin frequencies: 0=100Hz 1=150Hz 2=200Hz 3=250Hz 4=300Hz
  //                  5=350Hz 6=400Hz 7=450Hz 8=500Hz 9=550Hz
  localparam logic [9:0] BIN_BOUND [NBINS+1] = '{
    10'd143, 10'd183, 10'd223, 10'd263, 10'd303, 10'd343,
    10'd383, 10'd423, 10'd463, 10'd503, 10'd543
  };

  // Held bar after one frame of decay, floored at zero.
  function automatic height_t sat_decay(input height_t h);
    return (h >= height_t'(DECAY)) ? height_t'(h - height_t'(DECAY)) : '0;
  endfunction

endpackage

// File: rtl/bar_scale.sv
// Scales a raw bin magnitude down to screen lines and clamps it to the display height.
module bar_scale
  import spectrum_pkg::*;
(
  input  logic [MAG_W-1:0] mag,
  output logic [H_W-1:0]   height
);

  logic [MAG_W-SHIFT-1:0] scaled;

  assign scaled = mag[MAG_W-1:SHIFT];
  assign height = (scaled > (MAG_W-SHIFT)'(MAX_H)) ? H_W'(MAX_H) : H_W'(scaled);

endmodule

// File: rtl/spectrum_bar_buffer.sv
// Double-buffered bar height store: new heights collect in pending and are merged into
// the displayed set with peak-hold decay once per frame, during vertical blanking.
module spectrum_bar_buffer
  import spectrum_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             pix_en,
  input  logic [9:0]       vcs,
  input  logic [9:0]       hcs,
  input  logic             mag_valid,
  input  logic [3:0]       bin_idx,
  input  logic [MAG_W-1:0] mag,
  output logic [H_W-1:0]   hight,
  output logic             frame_tick
);

  height_t pending   [NBINS];
  height_t disp      [NBINS];
  height_t next_disp [NBINS];
  height_t scaled_h;
  logic    swap_tick;
  logic    wr_ok;

  bar_scale u_scale (
    .mag    (mag),
    .height (scaled_h)
  );

  assign swap_tick = pix_en && (vcs == 10'(VSWAP)) && (hcs == 10'd0);
  assign wr_ok     = mag_valid && (bin_idx < 4'(NBINS));

  always_comb begin
    for (int k = 0; k < NBINS; k++) begin
      next_disp[k] = (pending[k] > sat_decay(disp[k])) ? pending[k] : sat_decay(disp[k]);
    end
  end

  // Both arrays are reset so a mid-frame reset blanks every bar at once.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < NBINS; k++) begin
        pending[k] <= '0;
        disp[k]    <= '0;
      end
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= swap_tick;
      if (swap_tick) begin
        for (int k = 0; k < NBINS; k++) begin
          disp[k]    <= next_disp[k];
          pending[k] <= '0;
        end
      end
      // NOTE: the later non-blocking write overrides the clear above, so a write on the
      // swap cycle survives into the fresh pending set while the commit used the old value.
      if (wr_ok) begin
        pending[bin_idx] <= scaled_h;
      end
    end
  end

  // Zero-latency column decode against constant bounds; spans are disjoint.
  always_comb begin
    // NOTE: default first so every path assigns hight and no latch is inferred.
    hight = '0;
    for (int k = 0; k < NBINS; k++) begin
      if (hcs >= BIN_BOUND[k] && hcs < BIN_BOUND[k+1]) begin
        hight = disp[k];
      end
    end
  end

endmodule

// File: tb/tb_spectrum_bar_buffer.sv
// Directed bench for spectrum_bar_buffer with a frame-level reference model and literal checks.
module tb_spectrum_bar_buffer;

  logic        clk = 1'b0;
  logic        clr;
  logic        pix_en;
  logic [9:0]  vcs;
  logic [9:0]  hcs;
  logic        mag_valid;
  logic [3:0]  bin_idx;
  logic [15:0] mag;
  logic [8:0]  hight;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_pending [10];
  int m_disp    [10];
  int m_tick;

  spectrum_bar_buffer dut (
    .clk        (clk),
    .clr        (clr),
    .pix_en     (pix_en),
    .vcs        (vcs),
    .hcs        (hcs),
    .mag_valid  (mag_valid),
    .bin_idx    (bin_idx),
    .mag        (mag),
    .hight      (hight),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level behaviour in plain integer arithmetic.
  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 10; k++) begin
        m_pending[k] = 0;
        m_disp[k]    = 0;
      end
      m_tick = 0;
    end else begin
      m_tick = (pix_en && vcs == 512 && hcs == 0) ? 1 : 0;
      if (m_tick == 1) begin
        for (int k = 0; k < 10; k++) begin
          int held;
          held = (m_disp[k] > 4) ? m_disp[k] - 4 : 0;
          m_disp[k]    = (m_pending[k] > held) ? m_pending[k] : held;
          m_pending[k] = 0;
        end
      end
      if (mag_valid && bin_idx < 10) begin
        int s;
        s = int'(mag) / 128;
        m_pending[bin_idx] = (s > 480) ? 480 : s;
      end
    end
  end

  function automatic int model_h(input int col);
    if (col < 143 || col >= 143 + 10 * 40) return 0;
    return m_disp[(col - 143) / 40];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_hight", 32'(hight), 32'(model_h(int'(hcs))));
      check("model_frame_tick", 32'(frame_tick), 32'(m_tick));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int b, input int m);
    mag_valid = 1'b1;
    bin_idx   = 4'(b);
    mag       = 16'(m);
    tick();
    mag_valid = 1'b0;
  endtask

  task automatic do_swap();
    vcs = 10'd512;
    hcs = 10'd0;
    pix_en = 1'b1;
    tick();
    mag_valid = 1'b0;
    vcs = 10'd100;
    hcs = 10'd50;
    check("swap_frame_tick_pulse", 32'(frame_tick), 32'd1);
    tick();
    check("swap_frame_tick_clear", 32'(frame_tick), 32'd0);
  endtask

  task automatic peek(input string name, input int col, input int exp);
    hcs = 10'(col);
    #1;
    check(name, 32'(hight), 32'(exp));
  endtask

  initial begin
    clr = 1'b1; pix_en = 1'b1; vcs = 10'd100; hcs = 10'd0;
    mag_valid = 1'b0; bin_idx = 4'd0; mag = 16'd0;
    tick();
    tick();
    clr = 1'b0;
    chk_en = 1'b1;
    peek("init_hight", 150, 0);
    check("init_frame_tick", 32'(frame_tick), 32'd0);

    // Basic write and commit, with bin edges
    write(0, 12800);
    peek("pre_swap_bin0", 150, 0);
    do_swap();
    peek("basic_bin0", 150, 100);
    peek("basic_bin0_last", 182, 100);
    peek("basic_bin1_empty", 183, 0);
    peek("basic_left_margin", 100, 0);
    peek("basic_right_margin", 543, 0);

    // Mid-frame reset with bars shown; write during clr is dropped
    write(9, 16'hFFFF);
    mag_valid = 1'b1; bin_idx = 4'd1; mag = 16'd25600;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    mag_valid = 1'b0;
    peek("reset_bin0", 150, 0);
    peek("reset_bin8", 500, 0);
    check("reset_frame_tick", 32'(frame_tick), 32'd0);
    do_swap();
    peek("reset_bin1_dropped", 190, 0);
    peek("reset_bin9_cleared", 520, 0);

    // Clamp to MAX_H
    write(9, 16'hFFFF);
    do_swap();
    peek("clamp_bin9", 520, 480);
    peek("clamp_bin9_last", 542, 480);

    // Decay, including floor at zero
    write(2, 12800);
    write(4, 384);
    do_swap();
    peek("decay_bin2_f0", 230, 100);
    peek("decay_bin4_f0", 310, 3);
    do_swap();
    peek("decay_bin2_f1", 230, 96);
    peek("decay_bin4_f1", 310, 0);
    do_swap();
    peek("decay_bin2_f2", 230, 92);
    peek("decay_bin4_f2", 310, 0);
    do_swap();
    peek("decay_bin2_f3", 230, 88);
    peek("decay_bin4_f3", 310, 0);

    // Write coincident with swap tick
    write(3, 25600);
    mag_valid = 1'b1; bin_idx = 4'd3; mag = 16'd6400;
    do_swap();
    peek("coinc_bin3_now", 263, 200);
    do_swap();
    peek("coinc_bin3_next", 263, 196);

    // Illegal bin indices change nothing
    write(12, 16'hFFFF);
    write(10, 16'hFFFF);
    do_swap();
    peek("illegal_bin3", 263, 192);
    peek("illegal_bin9_margin", 543, 0);

    // Swap position with pix_en low: no commit
    write(6, 12800);
    vcs = 10'd512; hcs = 10'd0; pix_en = 1'b0;
    tick();
    pix_en = 1'b1; vcs = 10'd100; hcs = 10'd50;
    check("noswap_frame_tick", 32'(frame_tick), 32'd0);
    peek("noswap_bin3", 263, 192);
    peek("noswap_bin6", 390, 0);
    do_swap();
    peek("late_swap_bin6", 390, 100);

    // Last write to a bin within a frame wins
    write(5, 38400);
    write(5, 5120);
    do_swap();
    peek("lastwins_bin5", 350, 40);
    do_swap();
    peek("lastwins_bin5_decay", 350, 36);

    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
